// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths and the reservation-station entry layout
package alu_rs_pkg;
  localparam int ROBID_W = 4;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic valid;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] flags;
    logic [DATA_W-1:0] wbs;
    logic [ROBID_W-1:0] robid;
    logic [1:0] dep_rdy;
    logic [1:0][ROBID_W-1:0] dep_tag;
    logic [1:0][DATA_W-1:0] dep_val;
  } rs_entry_t;
endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB, FU-busy and issue signals of the ALU reservation station
interface alu_rs_if;
  import alu_rs_pkg::*;
  logic flush;
  logic disp_valid;
  logic disp_ready;
  logic [DATA_W-1:0] disp_operand;
  logic [DATA_W-1:0] disp_flags;
  logic [DATA_W-1:0] disp_wbs;
  logic [ROBID_W-1:0] disp_robid;
  logic [1:0] disp_dep_rdy;
  logic [1:0][ROBID_W-1:0] disp_dep_tag;
  logic [1:0][DATA_W-1:0] disp_dep_val;
  logic cdb_valid;
  logic [ROBID_W-1:0] cdb_id;
  logic [DATA_W-1:0] cdb_val;
  logic fu_busy;
  logic input_transmit;
  logic [DATA_W-1:0] operand;
  logic [1:0][DATA_W-1:0] depvals;
  logic [DATA_W-1:0] wbs;
  logic [DATA_W-1:0] flags;
  logic [ROBID_W-1:0] robid;
  modport slave (
    input flush, disp_valid, disp_operand, disp_flags, disp_wbs, disp_robid,
    input disp_dep_rdy, disp_dep_tag, disp_dep_val, cdb_valid, cdb_id, cdb_val, fu_busy,
    output disp_ready, input_transmit, operand, depvals, wbs, flags, robid
  );
  modport master (
    output flush, disp_valid, disp_operand, disp_flags, disp_wbs, disp_robid,
    output disp_dep_rdy, disp_dep_tag, disp_dep_val, cdb_valid, cdb_id, cdb_val, fu_busy,
    input disp_ready, input_transmit, operand, depvals, wbs, flags, robid
  );
endinterface

// File: rtl/rs_pick.sv
// rs_pick: one-hot grant of the lowest-index set request bit
module rs_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);
  // two's-complement trick isolates the lowest set bit
  always_comb begin
    gnt = req & (~req + N'(1));
    any = |req;
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and single-issue to the FU
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic   clk,
  input logic   rst,
  alu_rs_if.slave bus
);
  rs_entry_t ent [DEPTH];
  rs_entry_t nent;
  logic [DEPTH-1:0] vld, rdy, free_oh, sel_oh;
  logic has_free, has_rdy, do_disp, issue;

  rs_pick #(.N(DEPTH)) u_alloc (.req(~vld), .gnt(free_oh), .any(has_free));
  rs_pick #(.N(DEPTH)) u_sel (.req(rdy), .gnt(sel_oh), .any(has_rdy));

  assign bus.disp_ready = has_free;
  assign do_disp = bus.disp_valid & has_free;
  assign issue = has_rdy & ~bus.fu_busy;

  // eligibility from registered entry state only
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ent[i].valid;
      rdy[i] = ent[i].valid & (&ent[i].dep_rdy);
    end
  end

  // incoming entry, with same-cycle CDB capture for unready sources
  always_comb begin
    nent.valid = 1'b1;
    nent.operand = bus.disp_operand;
    nent.flags = bus.disp_flags;
    nent.wbs = bus.disp_wbs;
    nent.robid = bus.disp_robid;
    nent.dep_tag = bus.disp_dep_tag;
    for (int s = 0; s < 2; s++) begin
      nent.dep_rdy[s] = bus.disp_dep_rdy[s] | (bus.cdb_valid & bus.cdb_id == bus.disp_dep_tag[s]);
      nent.dep_val[s] = bus.disp_dep_rdy[s] ? bus.disp_dep_val[s] :
                        (bus.cdb_valid & bus.cdb_id == bus.disp_dep_tag[s]) ? bus.cdb_val : bus.disp_dep_val[s];
    end
  end

  // entry storage: allocate, free on issue, wake sources from the CDB
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || bus.flush) ent[i] <= '0;
      else if (do_disp && free_oh[i]) ent[i] <= nent;
      else begin
        if (issue && sel_oh[i]) ent[i].valid <= 1'b0;
        for (int s = 0; s < 2; s++)
          if (ent[i].valid && !ent[i].dep_rdy[s] && bus.cdb_valid && bus.cdb_id == ent[i].dep_tag[s]) begin
            ent[i].dep_rdy[s] <= 1'b1;
            ent[i].dep_val[s] <= bus.cdb_val;
          end
      end
    end
  end

  // registered issue port; payload holds when nothing issues
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.input_transmit <= 1'b0;
      bus.operand <= '0;
      bus.depvals <= '0;
      bus.wbs <= '0;
      bus.flags <= '0;
      bus.robid <= '0;
    end else begin
      bus.input_transmit <= issue;
      for (int i = 0; i < DEPTH; i++)
        if (issue && sel_oh[i]) begin
          bus.operand <= ent[i].operand;
          bus.depvals <= ent[i].dep_val;
          bus.wbs <= ent[i].wbs;
          bus.flags <= ent[i].flags;
          bus.robid <= ent[i].robid;
        end
    end
  end
endmodule
